// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the I/D memory bus arbiter.
// Holds the FSM encoding, owner type, bus command layout and the grant rule.
package mem_bus_arbiter_pkg;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_ADDR = 2'd1;
  localparam arb_state_t ST_DATA = 2'd2;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef struct packed {
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [3:0]            wstrb;
  } bus_cmd_t;

  // Once anything has completed, a contested grant alternates away from the last owner.
  function automatic logic pick_d(input logic want_i, input logic want_d,
                                  input logic served, input logic last_d,
                                  input logic d_priority);
    logic grant;
    if (want_i && want_d) begin
      if (served) begin
        grant = ~last_d;
      end else begin
        grant = d_priority;
      end
    end else begin
      grant = want_d;
    end
    return grant;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, one
// transaction at a time, with stall generation and flush draining.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_t state;
  arb_owner_t owner;
  logic       discard;
  logic       served;
  logic       grant_d;
  logic       data_done;
  logic       i_done;
  logic       d_done;

  // Grant decision and completion/stall decode.
  always_comb begin
    grant_d   = pick_d(i_req, d_req, served, owner == OWN_D, D_PRIORITY);
    data_done = (state == ST_DATA) && bus_data_ok;
    i_done    = data_done && (owner == OWN_I) && !discard;
    d_done    = data_done && (owner == OWN_D);
    // A flush releases the fetch stage at once; the bus side drains separately.
    i_stall   = i_req && !i_flush && !i_done;
    d_stall   = d_req && !d_done;
    i_rdata   = bus_rdata;
    d_rdata   = bus_rdata;
  end

  // Transaction FSM with registered bus address-phase outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_I;
      served    <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= SIZE_BYTE;
      bus_addr  <= {ADDR_W{1'b0}};
      bus_wdata <= {DATA_W{1'b0}};
      bus_wstrb <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            state   <= ST_ADDR;
            bus_req <= 1'b1;
            if (grant_d) begin
              owner     <= OWN_D;
              bus_wr    <= d_wr;
              bus_size  <= d_size;
              bus_addr  <= d_addr;
              bus_wdata <= d_wdata;
              bus_wstrb <= d_wstrb;
            end else begin
              owner     <= OWN_I;
              bus_wr    <= 1'b0;
              bus_size  <= SIZE_WORD;
              bus_addr  <= i_addr;
              bus_wdata <= {DATA_W{1'b0}};
              bus_wstrb <= 4'b0000;
            end
          end
        end
        ST_ADDR: begin
          if (bus_addr_ok) begin
            state   <= ST_DATA;
            bus_req <= 1'b0;
          end
        end
        ST_DATA: begin
          if (bus_data_ok) begin
            state  <= ST_IDLE;
            served <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Marks an in-flight fetch whose returning data must be dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      discard <= 1'b0;
    end else if ((state == ST_IDLE) || data_done) begin
      discard <= 1'b0;
    end else if (i_flush && (owner == OWN_I)) begin
      discard <= 1'b1;
    end else begin
      discard <= discard;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed cycle checks, then random
// I/D traffic against a reference memory model and a random bus responder.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_flush, i_stall;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_stall;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIORITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_stall(d_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic st; logic [31:0] data;} dexp_t;
  typedef struct {logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} btx_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] iq[$];
  dexp_t       dq[$];
  logic [31:0] ibusq[$];
  btx_t        dbusq[$];
  logic [31:0] rmem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];
  logic        rnd_done = 1'b0;
  logic        i_pend = 1'b0, d_pend = 1'b0;
  int          i_skip = 0, d_skip = 0;
  localparam int NI = 60;
  localparam int ND = 60;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] k);
    return {k[15:0], k[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] k);
    if (rmem.exists(k)) return rmem[k];
    return dflt(k);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] k);
    if (smem.exists(k)) return smem[k];
    return dflt(k);
  endfunction

  task automatic drive_i();
    logic [31:0] a;
    logic        ok;
    for (int n = 0; n < NI; n++) begin
      a = 32'hBFC0_0000 + (32'($urandom_range(0, 255)) << 2);
      iq.push_back(dflt(a));
      ibusq.push_back(a);
      i_pend = 1'b1;
      i_req = 1'b1; i_addr = a;
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (!i_stall) begin ok = 1'b1; break; end
      end
      chk("i_complete", {31'd0, ok}, 32'd1);
      step();
      i_req = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic drive_d();
    logic [31:0] a, wd, k, old;
    logic [1:0]  sz;
    logic [3:0]  st;
    logic        wr, ok;
    for (int n = 0; n < ND; n++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'h8000_0000 + (32'($urandom_range(0, 63)) << 2);
      if (sz == 2'd0) begin a[1:0] = 2'($urandom_range(0, 3)); st = 4'b0001 << a[1:0]; end
      else if (sz == 2'd1) begin a[1:0] = {1'($urandom_range(0, 1)), 1'b0}; st = 4'b0011 << a[1:0]; end
      else st = 4'b1111;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      k = {a[31:2], 2'b00};
      old = ref_rd(k);
      if (wr) rmem[k] = merge(old, wd, st);
      dq.push_back('{wr, old});
      dbusq.push_back('{wr, sz, a, wd, st});
      d_pend = 1'b1;
      d_req = 1'b1; d_wr = wr; d_size = sz; d_addr = a; d_wdata = wd; d_wstrb = st;
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (!d_stall) begin ok = 1'b1; break; end
      end
      chk("d_complete", {31'd0, ok}, 32'd1);
      step();
      d_req = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  // Random bus responder; also injects stray data_ok when nothing is in its data phase.
  task automatic slave();
    logic        pend, wr;
    int          dly;
    logic [31:0] a, wd;
    logic [3:0]  ws;
    pend = 1'b0; dly = 0; wr = 1'b0; a = 32'd0; wd = 32'd0; ws = 4'd0;
    while (!rnd_done) begin
      step();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          bus_data_ok = 1'b1;
          if (wr) begin
            smem[{a[31:2], 2'b00}] = merge(bus_rd({a[31:2], 2'b00}), wd, ws);
            bus_rdata = $urandom;
          end else bus_rdata = bus_rd({a[31:2], 2'b00});
          pend = 1'b0;
        end else dly--;
      end else if (bus_req && ($urandom_range(0, 1) == 1)) begin
        bus_addr_ok = 1'b1;
        a = bus_addr; wd = bus_wdata; ws = bus_wstrb; wr = bus_wr;
        pend = 1'b1; dly = $urandom_range(0, 3);
      end else if ($urandom_range(0, 7) == 0) begin
        bus_data_ok = 1'b1; bus_rdata = $urandom;
      end
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
  endtask

  task automatic monitor();
    logic [31:0] e;
    dexp_t       de;
    btx_t        be;
    while (!rnd_done) begin
      @(negedge clk);
      if (i_req && !i_stall) begin
        if (iq.size() == 0) chk("i_unexpected_delivery", 32'(iq.size()), 32'd1);
        else begin e = iq.pop_front(); chk("i_rdata", i_rdata, e); end
      end
      if (d_req && !d_stall) begin
        if (dq.size() == 0) chk("d_unexpected_delivery", 32'(dq.size()), 32'd1);
        else begin de = dq.pop_front(); if (!de.st) chk("d_rdata", d_rdata, de.data); end
      end
      if (bus_req && bus_addr_ok) begin
        if (bus_addr[31:28] == 4'hB) begin
          if (ibusq.size() == 0) chk("ibus_unexpected", 32'(ibusq.size()), 32'd1);
          else begin
            e = ibusq.pop_front();
            chk("ibus_addr", bus_addr, e);
            chk("ibus_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, {25'd0, 1'b0, 2'd2, 4'd0});
          end
          chk("i_rr_skips_le1", 32'(i_skip > 1), 32'd0);
          i_skip = 0; i_pend = 1'b0;
          if (d_pend) d_skip++;
        end else begin
          if (dbusq.size() == 0) chk("dbus_unexpected", 32'(dbusq.size()), 32'd1);
          else begin
            be = dbusq.pop_front();
            chk("dbus_addr", bus_addr, be.addr);
            chk("dbus_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, {25'd0, be.wr, be.size, be.wstrb});
            if (be.wr) chk("dbus_wdata", bus_wdata, be.wdata);
          end
          chk("d_rr_skips_le1", 32'(d_skip > 1), 32'd0);
          d_skip = 0; d_pend = 1'b0;
          if (i_pend) i_skip++;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = 32'd0; i_flush = 1'b0;
    d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
    repeat (3) step();
    smp();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, 32'd0);
    chk("rst_stalls", {30'd0, i_stall, d_stall}, 32'd0);
    chk("rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    step(); reset = 1'b1;

    // Isolated minimum-latency fetch.
    step(); i_req = 1'b1; i_addr = 32'hBFC0_0000;
    smp(); chk("t1_c0_stall", {31'd0, i_stall}, 32'd1); chk("t1_c0_bus_req", {31'd0, bus_req}, 32'd0);
    step(); bus_addr_ok = 1'b1;
    smp(); chk("t1_c1_stall", {31'd0, i_stall}, 32'd1); chk("t1_c1_bus_req", {31'd0, bus_req}, 32'd1);
    chk("t1_c1_addr", bus_addr, 32'hBFC0_0000);
    chk("t1_c1_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, {25'd0, 1'b0, 2'd2, 4'd0});
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C1D_8000;
    smp(); chk("t1_c2_stall", {31'd0, i_stall}, 32'd0); chk("t1_c2_rdata", i_rdata, 32'h3C1D_8000);
    chk("t1_c2_bus_req", {31'd0, bus_req}, 32'd0);
    step(); i_req = 1'b0; bus_data_ok = 1'b0;

    // Simultaneous I and D: load goes first, fetch waits through it.
    step(); i_req = 1'b1; i_addr = 32'hBFC0_0004;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h8000_1000; d_wstrb = 4'd0;
    smp(); chk("t2_both_stall", {30'd0, i_stall, d_stall}, 32'd3);
    step(); bus_addr_ok = 1'b1;
    smp(); chk("t2_d_addr", bus_addr, 32'h8000_1000); chk("t2_i_stall_a", {31'd0, i_stall}, 32'd1);
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1122_3344;
    smp(); chk("t2_d_done", {30'd0, i_stall, d_stall}, 32'd2); chk("t2_d_rdata", d_rdata, 32'h1122_3344);
    step(); d_req = 1'b0; bus_data_ok = 1'b0;
    smp(); chk("t2_i_stall_idle", {31'd0, i_stall}, 32'd1);
    step(); bus_addr_ok = 1'b1;
    smp(); chk("t2_i_addr", bus_addr, 32'hBFC0_0004); chk("t2_i_bus_req", {31'd0, bus_req}, 32'd1);
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0004;
    smp(); chk("t2_i_done", {31'd0, i_stall}, 32'd0); chk("t2_i_rdata", i_rdata, 32'h2408_0004);
    step(); i_req = 1'b0; bus_data_ok = 1'b0;

    // Byte store with a long data phase.
    step(); d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_addr = 32'h8000_0003;
    d_wstrb = 4'b1000; d_wdata = 32'hAB00_0000;
    step(); bus_addr_ok = 1'b1;
    smp(); chk("t3_ctl", {25'd0, bus_wr, bus_size, bus_wstrb}, {25'd0, 1'b1, 2'd0, 4'b1000});
    chk("t3_wdata", bus_wdata, 32'hAB00_0000); chk("t3_addr", bus_addr, 32'h8000_0003);
    step(); bus_addr_ok = 1'b0;
    smp(); chk("t3_wait_stall", {31'd0, d_stall}, 32'd1);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    smp(); chk("t3_done_stall", {31'd0, d_stall}, 32'd0);
    step(); d_req = 1'b0; d_wr = 1'b0; bus_data_ok = 1'b0;

    // Flush during a fetch's data phase; the next fetch waits for the drain.
    step(); i_req = 1'b1; i_addr = 32'hBFC0_0008;
    step(); bus_addr_ok = 1'b1;
    step(); bus_addr_ok = 1'b0; i_flush = 1'b1;
    smp(); chk("t4_flush_stall", {31'd0, i_stall}, 32'd0);
    step(); i_flush = 1'b0; i_req = 1'b0;
    smp(); chk("t4_drain_stall", {31'd0, i_stall}, 32'd0);
    step(); i_req = 1'b1; i_addr = 32'hBFC0_000C;
    smp(); chk("t4_new_stall", {31'd0, i_stall}, 32'd1); chk("t4_new_bus_req", {31'd0, bus_req}, 32'd0);
    step(); bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    smp(); chk("t4_dropped", {31'd0, i_stall}, 32'd1); chk("t4_drop_bus_req", {31'd0, bus_req}, 32'd0);
    step(); bus_data_ok = 1'b0;
    smp(); chk("t4_idle_bus_req", {31'd0, bus_req}, 32'd0);
    step(); bus_addr_ok = 1'b1;
    smp(); chk("t4_refetch_addr", bus_addr, 32'hBFC0_000C); chk("t4_refetch_req", {31'd0, bus_req}, 32'd1);
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_1111;
    smp(); chk("t4_refetch_done", {31'd0, i_stall}, 32'd0); chk("t4_refetch_rdata", i_rdata, 32'h0000_1111);
    step(); i_req = 1'b0; bus_data_ok = 1'b0;

    // Address phase held off for five cycles.
    step(); d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h8000_0010;
    d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step(); bus_addr_ok = 1'b0;
      smp(); chk("t5_hold", {bus_req, bus_wr, bus_wstrb, bus_addr[25:0]}, {1'b1, 1'b1, 4'hF, 26'h000_0010});
      chk("t5_hold_wdata", bus_wdata, 32'h1234_5678);
    end
    step(); bus_addr_ok = 1'b1;
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    smp(); chk("t5_done", {31'd0, d_stall}, 32'd0);
    step(); d_req = 1'b0; d_wr = 1'b0; bus_data_ok = 1'b0;

    // Reset during a data phase, then a late data_ok.
    step(); i_req = 1'b1; i_addr = 32'hBFC0_0010;
    step(); bus_addr_ok = 1'b1;
    step(); bus_addr_ok = 1'b0; reset = 1'b0;
    smp(); chk("t6_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("t6_rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
    step(); reset = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    smp(); chk("t6_late_ok_stall", {31'd0, i_stall}, 32'd1);
    step();
    smp(); chk("t6_spur_addr_stall", {31'd0, i_stall}, 32'd1); chk("t6_addr_req", {31'd0, bus_req}, 32'd1);
    step(); bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    step(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
    smp(); chk("t6_done", {31'd0, i_stall}, 32'd0); chk("t6_rdata", i_rdata, 32'h2408_0001);
    step(); i_req = 1'b0; bus_data_ok = 1'b0;

    // Random traffic against the scoreboard.
    step();
    fork
      begin
        fork
          drive_i();
          drive_d();
        join
        repeat (20) step();
        rnd_done = 1'b1;
      end
      slave();
      monitor();
    join
    chk("end_iq_empty", 32'(iq.size()), 32'd0);
    chk("end_dq_empty", 32'(dq.size()), 32'd0);
    chk("end_ibusq_empty", 32'(ibusq.size()), 32'd0);
    chk("end_dbusq_empty", 32'(dbusq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
